// File: rtl/ext_irq_arbiter.sv
// ext_irq_arbiter: machine-level external interrupt arbiter.
// Each source passes through a level or edge gateway. The arbiter registers
// the highest-priority enabled pending source above the threshold, and
// software takes and retires it through a claim/complete handshake.
//
// Handshake: i_claim is a single-cycle request with no ready; the answer is
// always o_claim_valid for exactly one cycle, one cycle later, with
// o_claim_id = 0 when nothing was claimable. i_complete is a fire-and-forget
// strobe qualified by i_complete_id.
module ext_irq_arbiter #(
  parameter int NUM_SOURCES = 8,
  parameter int PRIO_BITS   = 3,
  parameter int ID_W        = $clog2(NUM_SOURCES + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_SOURCES-1:0] i_irq_src,
  input  logic                   i_cfg_wr,
  input  logic [1:0]             i_cfg_sel,
  input  logic [ID_W-1:0]        i_cfg_idx,
  input  logic [PRIO_BITS-1:0]   i_cfg_wdata,
  input  logic                   i_claim,
  output logic                   o_claim_valid,
  output logic [ID_W-1:0]        o_claim_id,
  input  logic                   i_complete,
  input  logic [ID_W-1:0]        i_complete_id,
  output logic                   o_meip,
  output logic [NUM_SOURCES-1:0] o_pending,
  output logic [NUM_SOURCES-1:0] o_in_service
);

  localparam logic [1:0] SEL_PRIO = 2'd0;
  localparam logic [1:0] SEL_EN   = 2'd1;
  localparam logic [1:0] SEL_EDGE = 2'd2;
  localparam logic [1:0] SEL_THR  = 2'd3;

  logic [NUM_SOURCES-1:0] src_q, src_d;
  logic [NUM_SOURCES-1:0] src_prev_q, src_prev_d;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] in_service_q, in_service_d;
  logic [NUM_SOURCES-1:0] enable_q, enable_d;
  logic [NUM_SOURCES-1:0] edge_mode_q, edge_mode_d;
  logic [PRIO_BITS-1:0]   prio_q [NUM_SOURCES];
  logic [PRIO_BITS-1:0]   prio_d [NUM_SOURCES];
  logic [PRIO_BITS-1:0]   thr_q, thr_d;
  logic [ID_W-1:0]        best_id_q, best_id_d;
  logic [PRIO_BITS-1:0]   best_prio_q, best_prio_d;
  logic                   claim_valid_q, claim_valid_d;
  logic [ID_W-1:0]        claim_id_q, claim_id_d;

  logic [NUM_SOURCES-1:0] claim_hit;
  logic [NUM_SOURCES-1:0] complete_hit;
  logic [NUM_SOURCES-1:0] mode_flip;
  logic [ID_W-1:0]        arb_id;
  logic [PRIO_BITS-1:0]   arb_prio;
  logic                   claim_accept;

  // Config writes, gateways and in-service tracking.
  always_comb begin
    src_d        = i_irq_src;
    src_prev_d   = src_q;
    enable_d     = enable_q;
    edge_mode_d  = edge_mode_q;
    prio_d       = prio_q;
    thr_d        = thr_q;
    pending_d    = pending_q;
    in_service_d = in_service_q;
    mode_flip    = '0;
    claim_hit    = '0;
    complete_hit = '0;

    if (i_cfg_wr && (i_cfg_sel == SEL_THR)) begin
      thr_d = i_cfg_wdata;
    end

    for (int k = 0; k < NUM_SOURCES; k++) begin
      // Out-of-range or zero indices never match any source, so they drop.
      if (i_cfg_wr && (i_cfg_idx == ID_W'(k + 1))) begin
        case (i_cfg_sel)
          SEL_PRIO: prio_d[k] = i_cfg_wdata;
          SEL_EN:   enable_d[k] = i_cfg_wdata[0];
          SEL_EDGE: begin
            edge_mode_d[k] = i_cfg_wdata[0];
            // A gateway mode change discards whatever the old mode latched.
            mode_flip[k]   = (i_cfg_wdata[0] != edge_mode_q[k]);
          end
          default: ;
        endcase
      end

      claim_hit[k]    = i_claim && (best_id_q == ID_W'(k + 1));
      complete_hit[k] = i_complete && (i_complete_id == ID_W'(k + 1)) &&
                        in_service_q[k];

      if (edge_mode_q[k]) begin
        // Edges while pending or in service collapse into the existing request.
        pending_d[k] = pending_q[k] |
                       (src_q[k] & ~src_prev_q[k] & ~in_service_q[k]);
      end else begin
        pending_d[k] = src_q[k] & ~in_service_q[k];
      end
      if (claim_hit[k] || mode_flip[k]) begin
        pending_d[k] = 1'b0;
      end

      in_service_d[k] = (in_service_q[k] & ~complete_hit[k]) | claim_hit[k];
    end
  end

  // Arbitration: highest priority wins, strict compare keeps the lowest ID on ties.
  always_comb begin
    arb_id   = '0;
    arb_prio = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (pending_q[k] && enable_q[k] && (prio_q[k] > thr_q) &&
          (prio_q[k] > arb_prio)) begin
        arb_id   = ID_W'(k + 1);
        arb_prio = prio_q[k];
      end
    end

    // An accepted claim blanks the best register so the claimed source can
    // never be handed out twice while its pending bit is still being cleared.
    claim_accept  = i_claim && (best_id_q != '0);
    best_id_d     = claim_accept ? '0 : arb_id;
    best_prio_d   = claim_accept ? '0 : arb_prio;
    claim_valid_d = i_claim;
    claim_id_d    = i_claim ? best_id_q : '0;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      src_q         <= '0;
      src_prev_q    <= '0;
      pending_q     <= '0;
      in_service_q  <= '0;
      enable_q      <= '0;
      edge_mode_q   <= '0;
      thr_q         <= '0;
      best_id_q     <= '0;
      best_prio_q   <= '0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
      for (int k = 0; k < NUM_SOURCES; k++) begin
        prio_q[k] <= '0;
      end
    end else begin
      src_q         <= src_d;
      src_prev_q    <= src_prev_d;
      pending_q     <= pending_d;
      in_service_q  <= in_service_d;
      enable_q      <= enable_d;
      edge_mode_q   <= edge_mode_d;
      thr_q         <= thr_d;
      best_id_q     <= best_id_d;
      best_prio_q   <= best_prio_d;
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
      for (int k = 0; k < NUM_SOURCES; k++) begin
        prio_q[k] <= prio_d[k];
      end
    end
  end

  // A registered winner always carries a nonzero priority; both fields agree.
  assign o_meip        = (best_id_q != '0) && (best_prio_q != '0);
  assign o_claim_valid = claim_valid_q;
  assign o_claim_id    = claim_id_q;
  assign o_pending     = pending_q;
  assign o_in_service  = in_service_q;

endmodule

// File: doc/ext_irq_arbiter.md
# ext_irq_arbiter

Machine-level external interrupt arbiter. It collects up to NUM_SOURCES device interrupt lines, runs each through a level or edge gateway, and selects the highest-priority enabled pending source above a programmable threshold. It drives the single `meip` line consumed by the trap unit. Software takes and retires interrupts through a claim/complete handshake, so each source has at most one request in flight.

## Interface
- NUM_SOURCES, default 8: number of device sources; IDs 1..NUM_SOURCES; ID 0 means "none".
- PRIO_BITS, default 3: priority/threshold width; priority 0 means the source can never interrupt.
- ID_W, default $clog2(NUM_SOURCES+1): claim/complete ID width (derived).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_irq_src  in  NUM_SOURCES  device lines, already synchronous to i_clk; bit k is source ID k+1.
- i_cfg_wr  in  1  config write strobe.
- i_cfg_sel  in  2  write target: 0 = priority[idx], 1 = enable[idx], 2 = edge_mode[idx], 3 = threshold (idx ignored).
- i_cfg_idx  in  ID_W  target source ID; 0 or >NUM_SOURCES ignores the write (except sel 3).
- i_cfg_wdata  in  PRIO_BITS  write data; sel 1/2 use bit 0 only.
- i_claim  in  1  claim request pulse.
- o_claim_valid  out  1  one-cycle pulse, the cycle after i_claim.
- o_claim_id  out  ID_W  claimed ID, valid with o_claim_valid; 0 = nothing to claim.
- i_complete  in  1  complete strobe.
- i_complete_id  in  ID_W  ID being retired.
- o_meip  out  1  external interrupt pending, to the trap unit.
- o_pending  out  NUM_SOURCES  gateway pending bits (debug/CSR mirror).
- o_in_service  out  NUM_SOURCES  in-service bits.

## Operation
- Reset: pending, in_service, enable, edge_mode, priority, threshold, src_q, best register, o_claim_valid, o_claim_id and o_meip all 0.
- Input stage: src_q <= i_irq_src every cycle.
- Gateway, level mode:
  - pending[k] <= src_q[k] & ~in_service[k] & ~claim_hit[k].
  - pending[k] drops when the line drops before it is claimed.
- Gateway, edge mode:
  - A rising edge of src_q (compared with its previous sample) sets pending when the source is not in service.
  - Pending holds until claimed.
  - Edges arriving while pending or in service are dropped (no counting).
- Eligibility: pending & enable & (priority > threshold).
- Arbitration:
  - The highest priority wins; ties go to the lowest ID.
  - The result {best_id, best_prio} is registered every cycle.
  - o_meip = (best_id != 0), driven from the register.
- Claim (i_claim in cycle C):
  - o_claim_id <= best_id, o_claim_valid <= 1.
  - If best_id != 0: clear pending[best_id], set in_service[best_id], force best register to 0 at the same edge.
  - With best_id == 0 there is no state change.
- Complete:
  - If i_complete_id is in range and in_service is set, clear in_service.
  - Otherwise ignore.
- Config writes take effect at the next edge and influence arbitration one cycle later. Changing the edge_mode of a pending source clears its pending bit.

## Timing
- Latency from source to meip:
  - Line high before edge k: src_q at k, pending at k+1, best/o_meip at k+2.
  - Edge mode adds the edge compare with no extra cycle.
- Claim: o_claim_id/o_claim_valid are registered, visible the cycle after i_claim.
- After an accepted claim, o_meip is low for at least 1 cycle (best forced to 0). A claim in that cycle returns ID 0. The next best appears 1 cycle later.
- Same-cycle events:
  - Claim of X with an edge on X: the edge is dropped.
  - Complete of X with claim of Y: both apply.
  - Complete of X while line X is still high (level): pending re-sets 1 cycle after in_service clears.
  - Config write with claim: the claim uses the pre-write best register.
- Reset mid-operation clears in-flight claims; o_claim_valid is 0 the cycle after reset.

## Test plan
- Level basic: prio[3]=2, en[3]=1, thr=0; raise src ID3 at cycle 0 -> o_meip=1 at cycle 2; claim -> o_claim_id=3, o_meip=0 next cycle; line held, complete(3) -> pending[3] back 1 cycle later, o_meip 1 cycle after that.
- Priority/tie: IDs 2, 5, 6 pending with prios 4, 6, 6 -> claims return 5, then 6, then 2, then 0.
- Threshold: prio[4]=3, thr=3 -> o_meip stays 0; write thr=2 -> o_meip=1 two cycles later.
- Edge mode: ID1 edge, 3 more pulses before claim -> one claim returns 1, next returns 0; a pulse after complete(1) -> pending again.
- Back-to-back claims: IDs 1 and 2 pending, i_claim two consecutive cycles -> returns 1, then 0; third claim a cycle later -> 2.
- Robustness: complete(0), complete(NUM_SOURCES+1), complete of a non-in-service ID -> no state change; assert i_rst with ID 4 in service -> all outputs 0 the next cycle.
